// File: rtl/mem_bus_master.sv
// CPU load/store to waitrequest-style memory bus master.
// Handles lane select, sign extension, misalignment and stall timeout.
module mem_bus_master #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic [7:0]  cnt_inc;
    logic [31:0] rdata_nx;
    logic        err_nx;
    logic        bad_req;
    logic        active;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ld_data;
    logic [3:0]  be;
    logic [31:0] wd;

    always_comb begin
        bad_req = 1'b0;
        unique case (1'b1)
            (req_size == 2'b11): bad_req = 1'b1;
            (req_size == 2'b01): bad_req = req_addr[0];
            (req_size == 2'b10): bad_req = |req_addr[1:0];
            default:             bad_req = 1'b0;
        endcase
    end

    // Load lane extraction from the latched address
    always_comb begin
        rb = readdata[7:0];
        unique case (r_addr[1:0])
            2'd0: rb = readdata[7:0];
            2'd1: rb = readdata[15:8];
            2'd2: rb = readdata[23:16];
            2'd3: rb = readdata[31:24];
            default: rb = readdata[7:0];
        endcase
        rh = r_addr[1] ? readdata[31:16] : readdata[15:0];
        unique case (r_size)
            2'b00:   ld_data = {{24{r_signed & rb[7]}}, rb};
            2'b01:   ld_data = {{16{r_signed & rh[15]}}, rh};
            default: ld_data = readdata;
        endcase
    end

    always_comb begin
        unique case (r_size)
            2'b00: begin
                be = 4'b0001 << r_addr[1:0];
                wd = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                be = r_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{r_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = r_wdata;
            end
        endcase
    end

    assign cnt_inc = cnt + 8'd1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rdata_nx = resp_rdata;
        err_nx   = resp_err;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_nx = 8'd0;
                    if (bad_req) begin
                        state_nx = RESP;
                        err_nx   = 1'b1;
                        rdata_nx = 32'd0;
                    end else begin
                        state_nx = req_write ? WR : RD;
                    end
                end
            end
            RD, WR: begin
                if (!waitrequest) begin
                    state_nx = RESP;
                    err_nx   = 1'b0;
                    rdata_nx = (state == RD) ? ld_data : 32'd0;
                end else if (cnt_inc == 8'(MAX_WAIT)) begin
                    state_nx = RESP;
                    err_nx   = 1'b1;
                    rdata_nx = 32'd0;
                    cnt_nx   = cnt_inc;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            resp_rdata <= rdata_nx;
            resp_err   <= err_nx;
            if (state == IDLE && req_valid) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign read       = (state == RD);
    assign write      = (state == WR);
    assign active     = read | write;
    assign address    = active ? {r_addr[31:2], 2'b00} : 32'd0;
    assign byteenable = active ? be : 4'd0;
    assign writedata  = active ? wd : 32'd0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized self-checking bench for mem_bus_master.
// Expected values come from a size/offset arithmetic model.
module tb_mem_bus_master;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    function automatic logic m_bad(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
               (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] sz, logic [31:0] a);
        int nb = 1 << sz;
        int m = ((1 << nb) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wd(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ld(logic sg, logic [1:0] sz,
                                         logic [31:0] a, logic [31:0] rd);
        int bits = 8 << sz;
        logic [63:0] mask = (64'd1 << bits) - 64'd1;
        logic [63:0] v = ({32'd0, rd} >> (8 * a[1:0])) & mask;
        if (sg && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // Runs one request; reports what the bus and response did.
    task automatic drive_txn(
        input  logic w, input logic [1:0] sz, input logic sg,
        input  logic [31:0] a, input logic [31:0] wdat,
        input  logic [31:0] rd, input int stalls,
        output int n_str, output int lat,
        output logic [31:0] o_addr, output logic [3:0] o_be,
        output logic [31:0] o_wd, output logic [31:0] o_rdata,
        output logic o_err, output logic o_rd_seen,
        output logic o_wr_seen, output bit o_bad,
        output logic [31:0] o_hold);
        bit done = 0;
        n_str = 0; lat = -1; o_bad = 0;
        o_addr = 0; o_be = 0; o_wd = 0; o_rdata = 0; o_err = 0;
        o_rd_seen = 0; o_wr_seen = 0; o_hold = 0;
        @(negedge clk);
        if (!req_ready) o_bad = 1;
        req_valid = 1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wdat;
        waitrequest = (stalls > 0); readdata = rd;
        @(posedge clk);
        #1;
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (req_ready) o_bad = 1;
            if (read && write) o_bad = 1;
            if (read || write) begin
                n_str++;
                if (n_str == 1) begin
                    o_addr = address; o_be = byteenable; o_wd = writedata;
                end else if (address !== o_addr || byteenable !== o_be ||
                             writedata !== o_wd) begin
                    o_bad = 1;
                end
                o_rd_seen |= read;
                o_wr_seen |= write;
                waitrequest = (n_str <= stalls);
            end else if (address !== 0 || byteenable !== 0 || writedata !== 0) begin
                o_bad = 1;
            end
            if (resp_valid) begin
                lat = k; o_rdata = resp_rdata; o_err = resp_err;
                req_valid = 0; waitrequest = 0; done = 1;
            end
        end
        req_valid = 0;
        @(negedge clk);
        if (resp_valid || !req_ready || resp_err !== o_err) o_bad = 1;
        o_hold = resp_rdata;
    endtask

    // Drives a request and compares against the model.
    task automatic run_and_check(string nm, logic w, logic [1:0] sz,
                                 logic sg, logic [31:0] a, logic [31:0] wdat,
                                 logic [31:0] rd, int stalls);
        int n_str, lat, e_str;
        logic [31:0] o_addr, o_wd, o_rdata, o_hold, e_rdata;
        logic [3:0] o_be;
        logic o_err, o_rs, o_ws, e_err, bad;
        bit o_bad;
        drive_txn(w, sz, sg, a, wdat, rd, stalls, n_str, lat, o_addr, o_be,
                  o_wd, o_rdata, o_err, o_rs, o_ws, o_bad, o_hold);
        bad = m_bad(sz, a);
        e_str = bad ? 0 : (stalls >= MW ? MW : stalls + 1);
        e_err = bad || stalls >= MW;
        e_rdata = (e_err || w) ? 32'd0 : m_ld(sg, sz, a, rd);
        checks++;
        if (lat !== e_str + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, e_str + 1);
        end
        checks++;
        if (n_str !== e_str) begin
            errors++;
            $display("FAIL %s strobe_cycles: got %0d want %0d", nm, n_str, e_str);
        end
        checks++;
        if (o_err !== e_err) begin
            errors++;
            $display("FAIL %s resp_err: got %0b want %0b", nm, o_err, e_err);
        end
        checks++;
        if (o_rdata !== e_rdata || o_hold !== e_rdata) begin
            errors++;
            $display("FAIL %s resp_rdata: got %h/%h want %h", nm, o_rdata, o_hold, e_rdata);
        end
        checks++;
        if (o_bad) begin
            errors++;
            $display("FAIL %s protocol: got violation want none", nm);
        end
        if (e_str > 0) begin
            checks++;
            if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(sz, a)) begin
                errors++;
                $display("FAIL %s addr/be: got %h/%b want %h/%b", nm, o_addr,
                         o_be, {a[31:2], 2'b00}, m_be(sz, a));
            end
            checks++;
            if (o_rs !== !w || o_ws !== w) begin
                errors++;
                $display("FAIL %s strobe_kind: got rd=%0b wr=%0b want wr=%0b", nm, o_rs, o_ws, w);
            end
            if (w) begin
                checks++;
                if (o_wd !== m_wd(sz, wdat)) begin
                    errors++;
                    $display("FAIL %s writedata: got %h want %h", nm, o_wd, m_wd(sz, wdat));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++;
        if ({req_ready, resp_valid, resp_err, read, write} !== 5'b10000 ||
            resp_rdata !== 0 || address !== 0 || byteenable !== 0 ||
            writedata !== 0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b rv=%b re=%b rd=%b wr=%b rdata=%h want 1,0,0,0,0,0",
                     req_ready, resp_valid, resp_err, read, write, resp_rdata);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_directed();
        run_and_check("word_load", 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 0);
        run_and_check("sbyte_load", 0, 2'd0, 1, 32'h103, 0, 32'h80FF_0000, 0);
        run_and_check("ubyte_load", 0, 2'd0, 0, 32'h103, 0, 32'h80FF_0000, 0);
        run_and_check("half_store", 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 0, 3);
        run_and_check("shalf_load", 0, 2'd1, 1, 32'h302, 0, 32'h9000_1234, 1);
        run_and_check("misaligned", 0, 2'd2, 0, 32'h101, 0, 32'h1, 0);
        run_and_check("size11", 1, 2'd3, 0, 32'h100, 32'h5, 0, 0);
        run_and_check("timeout", 0, 2'd2, 0, 32'h400, 0, 32'hFFFF_FFFF, 50);
        run_and_check("edge_wait", 1, 2'd2, 0, 32'h404, 32'hCAFEF00D, 0, MW - 1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd2; req_addr = 32'h40;
        waitrequest = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (read !== 0 || resp_valid !== 0 || address !== 0 || req_ready !== 1) begin
            errors++;
            $display("FAIL reset_mid_abort: got rd=%b rv=%b addr=%h rdy=%b want 0,0,0,1",
                     read, resp_valid, address, req_ready);
        end
        @(negedge clk);
        rst_n = 1; waitrequest = 0;
        #1;
        checks++;
        if (req_ready !== 1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b want 1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 0 || read !== 0) begin
                errors++;
                $display("FAIL reset_mid_quiet: got rv=%b rd=%b want 0,0", resp_valid, read);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0] sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0 && sz == 2'd2) a[1:0] = 0;
            if ($urandom_range(0, 3) != 0 && sz == 2'd1) a[0] = 0;
            run_and_check("random", 1'($urandom), sz, 1'($urandom), a,
                          $urandom, $urandom, $urandom_range(0, MW + 1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the waitrequest cycles tolerated per bus access before timeout (1..255).
REQ-002 clk  input  1  rising-edge clock; the block SHALL have one clock.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU-side request strobe.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 req_signed  input  1  sign-extend load result.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, extended.
REQ-013 resp_err  output  1  misaligned, illegal-size or timeout; valid with resp_valid.
REQ-014 address  output  32  word-aligned bus address {req_addr[31:2],2'b00}.
REQ-015 read  output  1  bus read strobe.
REQ-016 write  output  1  bus write strobe.
REQ-017 byteenable  output  4  active byte lanes.
REQ-018 writedata  output  32  lane-replicated store data.
REQ-019 waitrequest  input  1  memory stall; access completes on a clk edge where it is low.
REQ-020 readdata  input  32  memory read data, sampled at completion edge.

Function
REQ-021 FSM states SHALL be IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, req_valid=1 SHALL latch all req_* inputs; misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL go to RESP with error set, no bus strobe; else go to WR (req_write=1) or RD.
REQ-023 In RD/WR, read/write SHALL be 1 with address, byteenable, writedata stable until completion or timeout.
REQ-024 byteenable SHALL be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-025 writedata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-026 Completion edge (waitrequest=0 in RD/WR) SHALL capture the selected readdata lane(s), extend (sign if req_signed else zero), go to RESP; WR results give resp_rdata=0.
REQ-027 A wait counter SHALL clear on entering RD/WR, increment on each edge with waitrequest=1; on reaching MAX_WAIT the block SHALL drop the strobe and go to RESP with error, resp_rdata=0.
REQ-028 RESP SHALL assert resp_valid for exactly one cycle then return to IDLE; resp_rdata/resp_err SHALL hold until the next RESP.
REQ-029 Latency: accept edge N, strobe high in cycle N+1, zero-wait completion at edge N+1, resp_valid in cycle N+2; next accept no earlier than edge N+3.
REQ-030 Outside RD/WR, read, write, byteenable, address and writedata SHALL be 0; read and write SHALL never be 1 together.
REQ-031 req_* changes while not in IDLE SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, counter 0, read=write=0, resp_valid=0, resp_err=0, resp_rdata=0, byteenable=0, address=0, writedata=0.
REQ-033 Reset during RD/WR SHALL abort the access with no resp_valid after release; req_ready=1 in the first cycle after release.

Verification
REQ-034 Word load addr 0x100, readdata=0xDEADBEEF, waitrequest=0 -> address=0x100, byteenable=1111, resp_rdata=0xDEADBEEF, resp_valid at accept+2 cycles.
REQ-035 Signed byte load addr 0x103, readdata=0x80FF_0000 -> byteenable=1000, resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Half store addr 0x202, wdata=0x1234ABCD, waitrequest high 3 cycles -> write held 4 cycles, address=0x200, byteenable=1100, writedata=0xABCDABCD, resp_err=0.
REQ-037 Word load addr 0x101 -> no read strobe, resp_valid with resp_err=1; size 11 -> same.
REQ-038 MAX_WAIT=4, waitrequest stuck high -> read high 4 cycles, dropped, resp_err=1, resp_rdata=0.
REQ-039 rst_n low on second stall cycle of a read -> read=0 immediately, no resp_valid, req_ready=1 after release.
